// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: MemOP codes, FSM state
// encoding and the width of the response timeout counter.
package lsu_pkg;

    // MemOP codes follow the RISC-V funct3 field of loads and stores
    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    // Timeout counter width; TIMEOUT must fit (1..255)
    localparam int CNT_W = 8;

    // Stores only know B/H/W; loads additionally accept the unsigned forms
    function automatic logic op_legal(input logic [2:0] op, input logic wen);
        logic ok;
        ok = 1'b0;
        case (op)
            MEM_B, MEM_H, MEM_W: ok = 1'b1;
            MEM_BU, MEM_HU:      ok = ~wen;
            default:             ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte-strobe and data replication, load
// byte/halfword extraction with sign or zero extension, and detection of
// misaligned or illegal operations.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic        wen_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  wmask_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        fault_o
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic        misalign;

    // Store side: strobes shifted to the addressed lane, data replicated so
    // the selected lane always carries the right-aligned source bits
    always_comb begin
        wmask_o = 4'b0000;
        wdata_o = wdata_i;
        case (op_i)
            MEM_B: begin
                wmask_o = 4'b0001 << off_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            MEM_H: begin
                wmask_o = 4'b0011 << off_i;
                wdata_o = {2{wdata_i[15:0]}};
            end
            MEM_W: begin
                wmask_o = 4'b1111;
                wdata_o = wdata_i;
            end
            default: begin
                wmask_o = 4'b0000;
                wdata_o = wdata_i;
            end
        endcase
    end

    // Load side: pick the addressed byte/halfword and extend it
    always_comb begin
        case (off_i)
            2'd0:    rd_byte = rdata_i[7:0];
            2'd1:    rd_byte = rdata_i[15:8];
            2'd2:    rd_byte = rdata_i[23:16];
            default: rd_byte = rdata_i[31:24];
        endcase
        rd_half = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (op_i)
            MEM_B:   rdata_o = {{24{rd_byte[7]}}, rd_byte};
            MEM_BU:  rdata_o = {24'h000000, rd_byte};
            MEM_H:   rdata_o = {{16{rd_half[15]}}, rd_half};
            MEM_HU:  rdata_o = {16'h0000, rd_half};
            MEM_W:   rdata_o = rdata_i;
            default: rdata_o = 32'h0000_0000;
        endcase
    end

    // Requests that must be answered with an error and never reach memory
    always_comb begin
        misalign = 1'b0;
        if ((op_i == MEM_H) || (op_i == MEM_HU)) begin
            misalign = off_i[0];
        end else if (op_i == MEM_W) begin
            misalign = (off_i != 2'b00);
        end
        fault_o = ~op_legal(op_i, wen_i) | misalign;
    end

endmodule

// File: rtl/lsu.sv
// Multi-cycle load/store unit between the core ALU stage and a valid/ready
// memory port. One request in flight; the core stalls while req_ready is low.
module lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp_err
);

    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      addr_q;
    logic [2:0]       op_q;
    logic             wen_q;
    logic [3:0]       wmask_q;
    logic [31:0]      wdata_q;
    logic             resp_valid_q, resp_valid_d;
    logic             resp_err_q, resp_err_d;
    logic [31:0]      resp_rdata_q, resp_rdata_d;

    logic             idle;
    logic             accept;
    logic [2:0]       a_op;
    logic             a_wen;
    logic [1:0]       a_off;
    logic [3:0]       a_wmask;
    logic [31:0]      a_wdata;
    logic [31:0]      a_rdata;
    logic             a_fault;

    assign idle   = (state_q == ST_IDLE);
    assign accept = idle & req_valid;

    // While idle the lane logic checks the incoming request; afterwards it
    // extracts load data using the latched op and offset
    assign a_op  = idle ? req_op         : op_q;
    assign a_wen = idle ? req_wen        : wen_q;
    assign a_off = idle ? req_addr[1:0]  : addr_q[1:0];

    lsu_align u_align (
        .op_i    (a_op),
        .wen_i   (a_wen),
        .off_i   (a_off),
        .wdata_i (req_wdata),
        .rdata_i (mem_rdata),
        .wmask_o (a_wmask),
        .wdata_o (a_wdata),
        .rdata_o (a_rdata),
        .fault_o (a_fault)
    );

    // Next state, timeout counter and response word
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'h0000_0000;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (a_fault) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (mem_resp_valid) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = mem_resp_err;
                    resp_rdata_d = (mem_resp_err | wen_q) ? 32'h0000_0000 : a_rdata;
                end else if (cnt_q == TO_LIMIT) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state: FSM and timeout counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Latched request and memory-side fields, held stable through REQ
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= 32'h0000_0000;
            op_q    <= MEM_B;
            wen_q   <= 1'b0;
            wmask_q <= 4'b0000;
            wdata_q <= 32'h0000_0000;
        end else if (accept) begin
            addr_q  <= req_addr;
            op_q    <= req_op;
            wen_q   <= req_wen;
            wmask_q <= req_wen ? a_wmask : 4'b0000;
            wdata_q <= req_wen ? a_wdata : 32'h0000_0000;
        end
    end

    // Registered response: a single-cycle pulse while in RESP
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0000_0000;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign req_ready     = idle;
    assign resp_valid    = resp_valid_q;
    assign resp_err      = resp_err_q;
    assign resp_rdata    = resp_rdata_q;
    assign mem_req_valid = (state_q == ST_REQ);
    assign mem_addr      = {addr_q[31:2], 2'b00};
    assign mem_wen       = wen_q;
    assign mem_wmask     = wmask_q;
    assign mem_wdata     = wdata_q;

endmodule
